// File: rtl/sram_init_writer.sv
`timescale 1ns/1ps
// sram_init_writer: fills every SRAM entry with INIT_VALUE after reset or reinit, then forwards write requests.
// Latency: one cycle from request handshake to the registered SRAM write; sweep writes one entry per cycle.
// Backpressure: req_ready is low outside RUN and during a reinit cycle; no buffering. SRAM_INIT_VERIFY_EN adds read-back verify.
module sram_init_writer #(
  parameter int DEPTH = 32,
  parameter int AW = 5,
  parameter int DW = 112,
  parameter logic [DW-1:0] INIT_VALUE = {DW{1'b0}}
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          reinit,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_data,
  output logic          req_drop,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [DW-1:0] mem_wdata,
  output logic [AW-1:0] mem_raddr,
  input  logic [DW-1:0] mem_rdata,
  output logic          init_busy,
  output logic          init_done,
  output logic          init_err
);

  localparam logic [1:0] ST_SWEEP = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd2;
`ifdef SRAM_INIT_VERIFY_EN
  localparam logic [1:0] ST_VERIFY = 2'd1;
`endif
  localparam logic [AW-1:0] LAST      = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_EXT = (AW+1)'(DEPTH);

  logic [1:0]    state;
  logic [AW-1:0] cnt;
  logic          in_range;

  // Requests are only taken in RUN; a reinit pulse blocks acceptance in its own cycle.
  assign req_ready = !rst && (state == ST_RUN) && !reinit;
  assign in_range  = ({1'b0, req_addr} < DEPTH_EXT);

`ifdef SRAM_INIT_VERIFY_EN
  logic vfy_tail;  // extra VERIFY cycle that checks the last read
  logic chk_vld;   // mem_rdata this cycle answers a verify read
  logic err_q;
  assign mem_raddr = (state == ST_VERIFY && !vfy_tail) ? cnt : '0;
  assign init_err  = err_q;
`else
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata;
  assign mem_raddr    = '0;
  assign init_err     = 1'b0;
`endif

  // Sequencer: sweep, optional verify, then request forwarding through the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_SWEEP;
      cnt       <= '0;
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      req_drop  <= 1'b0;
      init_done <= 1'b0;
      init_busy <= 1'b1;
`ifdef SRAM_INIT_VERIFY_EN
      vfy_tail  <= 1'b0;
      chk_vld   <= 1'b0;
      err_q     <= 1'b0;
`endif
    end else begin
      mem_we    <= 1'b0;
      req_drop  <= 1'b0;
      init_done <= (state == ST_RUN);
      init_busy <= (state != ST_RUN);
`ifdef SRAM_INIT_VERIFY_EN
      if (chk_vld && (mem_rdata != INIT_VALUE)) err_q <= 1'b1;
      chk_vld <= 1'b0;
`endif
      case (state)
        ST_SWEEP: begin
          mem_we    <= 1'b1;
          mem_waddr <= cnt;
          mem_wdata <= INIT_VALUE;
          if (cnt == LAST) begin
            cnt <= '0;
`ifdef SRAM_INIT_VERIFY_EN
            state <= ST_VERIFY;
`else
            state <= ST_RUN;
`endif
          end else begin
            cnt <= cnt + AW'(1);
          end
        end
`ifdef SRAM_INIT_VERIFY_EN
        ST_VERIFY: begin
          if (vfy_tail) begin
            vfy_tail <= 1'b0;
            state    <= ST_RUN;
          end else begin
            chk_vld <= 1'b1;
            if (cnt == LAST) begin
              cnt      <= '0;
              vfy_tail <= 1'b1;
            end else begin
              cnt <= cnt + AW'(1);
            end
          end
        end
`endif
        default: begin
          if (reinit) begin
            state <= ST_SWEEP;
            cnt   <= '0;
`ifdef SRAM_INIT_VERIFY_EN
            err_q <= 1'b0;
`endif
          end else if (req_valid && req_ready) begin
            if (in_range) begin
              mem_we    <= 1'b1;
              mem_waddr <= req_addr;
              mem_wdata <= req_data;
            end else begin
              req_drop <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule
